// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator job controller.
// Holds the FSM encoding, datapath widths, int8 limits and the latched job config.
package acc_pkg;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned ST_W  = 3;

    localparam logic [7:0] INT8_MAX = 8'h7f;
    localparam logic [7:0] INT8_MIN = 8'h80;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_ACC  = 3'd3,
        ST_RESP = 3'd4
    } acc_state_e;

    // Job parameters captured on the start handshake.
    typedef struct packed {
        logic             preload;
        logic [ACC_W-1:0] bias;
    } job_cfg_t;

endpackage

// File: rtl/acc_beat_cnt.sv
// Loadable down-counter tracking remaining input beats of a job.
// Saturates at zero; last_c flags the final outstanding beat.
module acc_beat_cnt
    import acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             last_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - LEN_W'(1);
        end
    end

    assign last_c = (count == LEN_W'(1));

endmodule

// File: rtl/acc_ctrl.sv
// Job controller sequencing clear/preload, beat accumulation and result hand-off
// for an external int16 accumulator with saturated int8 view.
module acc_ctrl
    import acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_vld,
    output logic             start_rdy,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_preload,
    input  logic [ACC_W-1:0] bias_data,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [ACC_W-1:0] in_data,
    input  logic             abort,
    output logic             acc_clr,
    output logic             load_vld,
    output logic             acc_vld,
    output logic [ACC_W-1:0] load_data,
    output logic [ACC_W-1:0] acc_data,
    input  logic [ACC_W-1:0] acc_q16,
    input  logic [7:0]       acc_q8,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [ACC_W-1:0] res_data16,
    output logic [7:0]       res_data8,
    output logic             busy
);

    acc_state_e       state_q, state_d;
    job_cfg_t         cfg_q;
    logic             cfg_we;
    logic             cnt_clr, cnt_load, cnt_dec;
    logic [LEN_W-1:0] cnt;
    logic             cnt_last;

    acc_beat_cnt u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cfg_len),
        .dec      (cnt_dec),
        .count    (cnt),
        .last_c   (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (cfg_we) begin
            cfg_q <= '{preload: cfg_preload, bias: bias_data};
        end
    end

    // Next state and per-state accumulator commands; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        start_rdy = 1'b0;
        in_rdy    = 1'b0;
        acc_clr   = 1'b0;
        load_vld  = 1'b0;
        acc_vld   = 1'b0;
        load_data = '0;
        acc_data  = '0;
        res_vld   = 1'b0;
        busy      = 1'b1;
        cfg_we    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                start_rdy = 1'b1;
                if (start_vld) begin
                    cfg_we   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = cfg_preload ? ST_LOAD : ST_CLR;
                end
            end
            ST_CLR: begin
                acc_clr = 1'b1;
                state_d = (cnt != '0) ? ST_ACC : ST_RESP;
            end
            ST_LOAD: begin
                load_vld  = 1'b1;
                load_data = cfg_q.bias;
                state_d   = (cnt != '0) ? ST_ACC : ST_RESP;
            end
            ST_ACC: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    acc_vld  = 1'b1;
                    acc_data = in_data;
                    cnt_dec  = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                res_vld = 1'b1;
                if (res_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            acc_clr   = 1'b1;
            load_vld  = 1'b0;
            acc_vld   = 1'b0;
            load_data = '0;
            acc_data  = '0;
            res_vld   = 1'b0;
            in_rdy    = 1'b0;
            cnt_dec   = 1'b0;
            cnt_clr   = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    assign res_data16 = acc_q16;
    assign res_data8  = acc_q8;

endmodule

// File: tb/tb_acc_ctrl.sv
// Randomized self-checking bench for acc_ctrl with a saturating accumulator stub
// and a job-level reference model (expected sum, latency, command sequence).
module tb_acc_ctrl;
    import acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_vld, start_rdy;
    logic [7:0]  cfg_len;
    logic        cfg_preload;
    logic [15:0] bias_data;
    logic        in_vld, in_rdy;
    logic [15:0] in_data;
    logic        abort;
    logic        acc_clr, load_vld, acc_vld;
    logic [15:0] load_data, acc_data;
    logic [15:0] acc_q16;
    logic [7:0]  acc_q8;
    logic        res_vld, res_rdy;
    logic [15:0] res_data16;
    logic [7:0]  res_data8;
    logic        busy;

    always #5 clk = ~clk;

    acc_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .start_vld(start_vld), .start_rdy(start_rdy),
        .cfg_len(cfg_len), .cfg_preload(cfg_preload), .bias_data(bias_data),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .abort(abort),
        .acc_clr(acc_clr), .load_vld(load_vld), .acc_vld(acc_vld),
        .load_data(load_data), .acc_data(acc_data),
        .acc_q16(acc_q16), .acc_q8(acc_q8),
        .res_vld(res_vld), .res_rdy(res_rdy),
        .res_data16(res_data16), .res_data8(res_data8),
        .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767)  return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic logic [7:0] sat8(input logic [15:0] a);
        int v;
        v = int'($signed(a));
        if (v > 127)  return INT8_MAX;
        if (v < -128) return INT8_MIN;
        return 8'(v);
    endfunction

    // External accumulator: clear / load / saturating add on the controller's commands.
    logic [15:0] acc_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc_reg <= '0;
        else if (acc_clr)  acc_reg <= '0;
        else if (load_vld) acc_reg <= load_data;
        else if (acc_vld)  acc_reg <= sat16(int'($signed(acc_reg)) + int'($signed(acc_data)));
    end
    assign acc_q16 = acc_reg;
    assign acc_q8  = sat8(acc_reg);

    // Job description consumed by run_job.
    bit          j_pre;
    logic [15:0] j_bias;
    int          j_n;
    logic [15:0] j_beat [256];
    int          j_gap  [256];
    int          j_abort_at;
    int          j_stall;

    function automatic logic [2:0] cmd();
        return {acc_clr, load_vld, acc_vld};
    endfunction

    task automatic setup(input bit pre, input logic [15:0] bias, input int n,
                         input int abort_at, input int stall);
        j_pre = pre; j_bias = bias; j_n = n; j_abort_at = abort_at; j_stall = stall;
        for (int i = 0; i < 256; i++) begin
            j_beat[i] = 16'(i);
            j_gap[i]  = 0;
        end
    endtask

    // Entry and exit point: 1 time unit after a rising edge.
    task automatic run_job(input string nm);
        logic [15:0] exp16;
        int gaps, k, sent, g, w;
        bit ab;

        exp16 = j_pre ? j_bias : 16'h0000;
        gaps  = 0;
        for (int i = 0; i < j_n; i++) begin
            exp16 = sat16(int'($signed(exp16)) + int'($signed(j_beat[i])));
            gaps += j_gap[i];
        end

        w = 0;
        while (!start_rdy && w < 400) begin @(posedge clk); #1; w++; end
        start_vld = 1'b1; cfg_len = 8'(j_n); cfg_preload = j_pre; bias_data = j_bias;
        in_vld = 1'b0; abort = 1'b0; res_rdy = 1'($urandom);
        @(negedge clk);
        check({nm, " idle_start_rdy"}, 32'(start_rdy), 32'd1);
        check({nm, " idle_busy"}, 32'(busy), 32'd0);

        @(posedge clk); #1;
        start_vld = 1'b0; cfg_len = 8'($urandom); cfg_preload = 1'($urandom); bias_data = 16'($urandom);
        k = 0;
        @(negedge clk);
        check({nm, " first_cmd"}, 32'(cmd()), j_pre ? 32'b010 : 32'b100);
        if (j_pre) check({nm, " load_data"}, 32'(load_data), 32'(j_bias));
        check({nm, " busy_start"}, 32'(busy), 32'd1);
        check({nm, " start_rdy_busy"}, 32'(start_rdy), 32'd0);

        @(posedge clk); #1; k++;
        sent = 0; g = 0; ab = 1'b0;
        while (sent < j_n && !ab && k < 4000) begin
            if (g < j_gap[sent]) begin in_vld = 1'b0; g++; end
            else in_vld = 1'b1;
            in_data   = in_vld ? j_beat[sent] : 16'($urandom);
            abort     = in_vld && (j_abort_at == sent + 1);
            res_rdy   = 1'($urandom);
            start_vld = 1'($urandom);
            @(negedge clk);
            if (!abort) check({nm, " in_rdy"}, 32'(in_rdy), 32'd1);
            check({nm, " beat_cmd"}, 32'(cmd()), abort ? 32'b100 : (in_vld ? 32'b001 : 32'b000));
            if (in_vld && !abort) check({nm, " acc_data"}, 32'(acc_data), 32'(j_beat[sent]));
            check({nm, " no_res_early"}, 32'(res_vld), 32'd0);
            @(posedge clk); #1; k++;
            if (abort) ab = 1'b1;
            else if (in_vld) begin sent++; g = 0; end
        end
        in_vld = 1'b0; abort = 1'b0; start_vld = 1'b0; res_rdy = 1'b0;

        if (ab) begin
            @(negedge clk);
            check({nm, " abort_idle_busy"}, 32'(busy), 32'd0);
            check({nm, " abort_start_rdy"}, 32'(start_rdy), 32'd1);
            check({nm, " abort_no_res"}, 32'(res_vld), 32'd0);
            check({nm, " abort_acc_cleared"}, 32'(acc_q16), 32'd0);
            @(posedge clk); #1;
            return;
        end

        w = 0;
        @(negedge clk);
        while (!res_vld && w < 8) begin
            @(posedge clk); #1; k++; w++;
            @(negedge clk);
        end
        check({nm, " res_vld"}, 32'(res_vld), 32'd1);
        check({nm, " latency"}, 32'(k), 32'(j_n + 1 + gaps));
        check({nm, " res16"}, 32'(res_data16), 32'(exp16));
        check({nm, " res8"}, 32'(res_data8), 32'(sat8(exp16)));
        check({nm, " resp_cmd"}, 32'(cmd()), 32'd0);

        for (int s = 1; s < j_stall; s++) begin
            @(posedge clk); #1;
            start_vld = 1'b1;
            @(negedge clk);
            check({nm, " hold_vld"}, 32'(res_vld), 32'd1);
            check({nm, " hold16"}, 32'(res_data16), 32'(exp16));
            check({nm, " resp_no_start"}, 32'(start_rdy), 32'd0);
        end
        @(posedge clk); #1;
        res_rdy = 1'b1; start_vld = 1'b0;
        @(negedge clk);
        check({nm, " resp_last"}, 32'(res_vld), 32'd1);
        @(posedge clk); #1;
        res_rdy = 1'b0;
        @(negedge clk);
        check({nm, " back_idle"}, 32'({busy, start_rdy, res_vld}), 32'b010);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start_vld = 1'b0; cfg_len = '0; cfg_preload = 1'b0; bias_data = '0;
        in_vld = 1'b0; in_data = '0; abort = 1'b0; res_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({start_rdy, busy, in_rdy, res_vld, cmd()}), 32'b1000000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // abort while IDLE is a no-op
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort_cmd", 32'(cmd()), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_state", 32'({start_rdy, busy}), 32'b10);
        @(posedge clk); #1;

        setup(1'b0, 16'h0, 3, 0, 1);
        j_beat[0] = 16'd5; j_beat[1] = 16'hfffe; j_beat[2] = 16'd7;
        run_job("basic");

        setup(1'b1, 16'h7ff0, 2, 0, 1);
        j_beat[0] = 16'h0010; j_beat[1] = 16'h0010;
        run_job("sat_pos");

        setup(1'b1, 16'hfed4, 0, 0, 1);
        run_job("n0_neg");

        setup(1'b0, 16'h0, 4, 0, 1);
        j_beat[0] = 16'd100; j_beat[1] = 16'd200; j_beat[2] = 16'hffce; j_beat[3] = 16'd1;
        j_gap[2] = 3;
        run_job("gap");

        setup(1'b0, 16'h0, 5, 2, 1);
        run_job("abort");

        setup(1'b1, 16'h0003, 2, 0, 5);
        j_beat[0] = 16'd4; j_beat[1] = 16'd9;
        run_job("stall");

        setup(1'b0, 16'h0, 255, 0, 2);
        for (int i = 0; i < 255; i++) j_beat[i] = 16'd200;
        run_job("n255");

        for (int t = 0; t < 40; t++) begin
            setup(1'($urandom), 16'($urandom), int'($urandom_range(0, 12)), 0,
                  int'($urandom_range(1, 5)));
            for (int i = 0; i < j_n; i++) begin
                j_beat[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255) - 128);
                j_gap[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            if (j_n > 0 && $urandom_range(0, 5) == 0) j_abort_at = int'($urandom_range(1, j_n));
            run_job("rand");
        end

        // reset in mid-job: job dropped, no clear command from reset itself
        start_vld = 1'b1; cfg_len = 8'd6; cfg_preload = 1'b0;
        @(posedge clk); #1;
        start_vld = 1'b0;
        @(posedge clk); #1;
        in_vld = 1'b1; in_data = 16'd3;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({start_rdy, busy, in_rdy, res_vld, cmd()}), 32'b1000000);
        @(posedge clk); #1;
        rst_n = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        check("midrst_idle", 32'({start_rdy, busy, cmd()}), 32'b10000);
        @(posedge clk); #1;

        setup(1'b0, 16'h0, 2, 0, 1);
        j_beat[0] = 16'hff80; j_beat[1] = 16'hfff0;
        run_job("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
